// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encoding,
// requester count and select width, plus a one-hot helper.
package mux_arb_defs;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = {{(N_REQ-1){1'b0}}, 1'b1};
    return v << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_picker.sv
// Rotating priority encoder: first set request searching upward from last+1,
// wrapping modulo the requester count.
module rr_grant_picker
  import mux_arb_defs::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan the four positions after last; the first hit wins.
  always_comb begin
    pick = 2'd0;
    any  = 1'b0;
    idx  = 2'd0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last + i[SEL_W-1:0];
      if (!any && req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end else begin
        pick = pick;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 data mux; grants one
// requester for up to MAX_BURST valid/ready beats, then re-arbitrates.
module mux_rr_arbiter
  import mux_arb_defs::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  input  logic                    ready_in,
  output logic [N_REQ-1:0]        grant,
  output logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_t           state_r, state_s;
  logic [SEL_W-1:0] sel_r, sel_s;
  logic [SEL_W-1:0] last_r, last_s;
  logic [N_REQ-1:0] grant_r, grant_s;
  logic [CNT_W-1:0] beat_cnt_r, beat_cnt_s;
  logic [SEL_W-1:0] pick_s;
  logic             any_s;
  logic             beat_s;

  rr_grant_picker u_picker (
    .req  (req),
    .last (last_r),
    .pick (pick_s),
    .any  (any_s)
  );

  assign busy      = (state_r == GRANT);
  assign grant     = grant_r;
  assign sel       = sel_r;
  assign out_valid = busy & req[sel_r];
  assign out_data  = data_in[sel_r*DATA_W +: DATA_W];
  assign beat_s    = out_valid & ready_in;

  // Next-state: arbitrate in IDLE, count beats and decide release in GRANT.
  always_comb begin
    state_s    = state_r;
    sel_s      = sel_r;
    last_s     = last_r;
    grant_s    = grant_r;
    beat_cnt_s = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          sel_s      = pick_s;
          grant_s    = onehot_sel(pick_s);
          beat_cnt_s = {CNT_W{1'b0}};
          state_s    = GRANT;
        end else begin
          grant_s = {N_REQ{1'b0}};
        end
      end
      GRANT: begin
        if (!req[sel_r]) begin
          last_s  = sel_r;
          grant_s = {N_REQ{1'b0}};
          state_s = IDLE;
        end else if (beat_s) begin
          beat_cnt_s = beat_cnt_r + 1'b1;
          if (beat_cnt_r + 1'b1 == MAX_CNT) begin
            last_s  = sel_r;
            grant_s = {N_REQ{1'b0}};
            state_s = IDLE;
          end else begin
            state_s = GRANT;
          end
        end else begin
          state_s = GRANT;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = {N_REQ{1'b0}};
      end
    endcase
  end

  // State registers; last resets to 3 so requester 0 has first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      sel_r      <= 2'd0;
      last_r     <= 2'd3;
      grant_r    <= 4'b0000;
      beat_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      sel_r      <= sel_s;
      last_r     <= last_s;
      grant_r    <= grant_s;
      beat_cnt_r <= beat_cnt_s;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter.
module tb_mux_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        ready_in;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mux_rr_arbiter #(.DATA_W(8), .MAX_BURST(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts beats of the current grant until release, then checks the bubble.
  task automatic run_grant(input logic [3:0] exp_grant, input logic [1:0] exp_sel, input int exp_beats);
    int cnt;
    int n;
    cnt = 0;
    n = 0;
    checks++;
    if (grant !== exp_grant || sel !== exp_sel) begin
      errors++;
      $display("FAIL grant_sel: grant=%b sel=%0d want grant=%b sel=%0d", grant, sel, exp_grant, exp_sel);
    end
    while (busy && n < 40) begin
      if (out_valid && ready_in) cnt++;
      cyc();
      n++;
    end
    checks++;
    if (cnt !== exp_beats) begin
      errors++;
      $display("FAIL beat_count: got %0d want %0d (sel %0d)", cnt, exp_beats, exp_sel);
    end
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bubble: grant=%b busy=%b want 0000/0", grant, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; ready_in = 1'b0;
    cyc(); cyc();
    checks++;
    if (grant !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: grant=%b sel=%0d busy=%b valid=%b want 0000/0/0/0", grant, sel, busy, out_valid);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: busy=%b want 0", busy);
    end
  endtask

  task automatic test_single();
    req = 4'b0010; ready_in = 1'b1;
    cyc();
    checks++;
    if (out_data !== 8'hA5 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_data: data=%h valid=%b want a5/1", out_data, out_valid);
    end
    run_grant(4'b0010, 2'd1, 4);
    cyc();
    checks++;
    if (grant !== 4'b0010 || sel !== 2'd1) begin
      errors++;
      $display("FAIL regrant: grant=%b sel=%0d want 0010/1", grant, sel);
    end
    req = 4'b0000;
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_release: busy=%b want 0", busy);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [5];
    logic [1:0] exp_s [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1; req = 4'b1111; ready_in = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      run_grant(exp_g[k], exp_s[k], 4);
      if (k < 4) cyc();
    end
  endtask

  task automatic test_early_drop();
    req = 4'b0100; ready_in = 1'b1;
    cyc();
    checks++;
    if (grant !== 4'b0100 || out_data !== 8'h33) begin
      errors++;
      $display("FAIL drop_grant: grant=%b data=%h want 0100/33", grant, out_data);
    end
    cyc(); cyc();
    req = 4'b1011;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_valid: valid=%b busy=%b want 0/1", out_valid, busy);
    end
    cyc();
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL drop_rel: grant=%b want 0000", grant);
    end
    cyc();
    checks++;
    if (sel !== 2'd3 || grant !== 4'b1000 || out_data !== 8'h44) begin
      errors++;
      $display("FAIL after_drop_pick: sel=%0d grant=%b data=%h want 3/1000/44", sel, grant, out_data);
    end
    req = 4'b0000;
    cyc(); cyc();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    req = 4'b0001; ready_in = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      if (grant !== 4'b0001 || out_data !== 8'h11 || out_valid !== 1'b1) bad++;
      cyc();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d unstable cycles want 0", bad);
    end
    ready_in = 1'b1;
    run_grant(4'b0001, 2'd0, 4);
    req = 4'b0000;
    cyc();
  endtask

  task automatic test_reset_mid();
    req = 4'b1000; ready_in = 1'b1;
    cyc();
    checks++;
    if (grant !== 4'b1000 || out_data !== 8'h44) begin
      errors++;
      $display("FAIL mid_grant: grant=%b data=%h want 1000/44", grant, out_data);
    end
    cyc(); cyc();
    rst = 1'b1; req = 4'b1001;
    cyc();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: grant=%b busy=%b sel=%0d want 0000/0/0", grant, busy, sel);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (grant !== 4'b0001 || sel !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_pick: grant=%b sel=%0d want 0001/0", grant, sel);
    end
    req = 4'b0000;
    cyc(); cyc();
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    ready_in = 1'b0;
    data_in = {8'h44, 8'h33, 8'hA5, 8'h11};
    test_reset();
    test_single();
    test_rotation();
    test_early_drop();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
